// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive FIFO.
//   uart_entry_t : one stored entry, {err, data}
//   rd_mode_e    : read-port mode (registered / show-ahead)
//   cnt_w()      : bits needed to count 0..n inclusive
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum bit {
    RD_REGISTERED = 1'b0,
    RD_SHOW_AHEAD = 1'b1
  } rd_mode_e;

  typedef struct packed {
    logic                   err;
    logic [UART_DATA_W-1:0] data;
  } uart_entry_t;

  // Bits needed to represent 0..n (one more than log2 for powers of two).
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_tout.sv
// Idle timeout for the receive FIFO.
//   CLKip/RSTi : clock, async active-low reset
//   ACTi       : an accepted read or write this cycle
//   EMPTYi     : FIFO empty (nothing to time out on)
//   FLUSHi     : flush this cycle
//   TOUTo      : TOUT_CYC consecutive idle, non-empty cycles have elapsed
module uart_fifo_tout
  import uart_pkg::*;
#(
  parameter int TOUT_CYC = 1024
) (
  input  logic CLKip,
  input  logic RSTi,
  input  logic ACTi,
  input  logic EMPTYi,
  input  logic FLUSHi,
  output logic TOUTo
);

  localparam int            CW    = cnt_w(TOUT_CYC);
  localparam logic [CW-1:0] LIMIT = CW'(TOUT_CYC);

  logic [CW-1:0] cnt;

  // Saturates at LIMIT so TOUTo stays up until activity or a flush.
  always_ff @(posedge CLKip or negedge RSTi) begin
    if (!RSTi)                        cnt <= '0;
    else if (ACTi || EMPTYi || FLUSHi) cnt <= '0;
    else if (cnt != LIMIT)            cnt <= cnt + CW'(1);
  end

  assign TOUTo = (cnt == LIMIT);

endmodule

// File: rtl/uart_rx_fifo_lvl.sv
// UART receive FIFO with level status, sticky error flags, idle timeout
// and a registered interrupt.
//   CLKip/RSTi            : clock, async active-low reset
//   WEi/WDi/WERRi         : write strobe, data, frame/parity error tag
//   REi                   : read request
//   RDo/RERRo/RVALIDo     : read data, error tag, data valid
//   FLUSHi/CLRi           : sync flush, clear sticky OVFo/UDFo
//   AFULL_THi/AEMPTY_THi  : almost-full / almost-empty levels
//   FULLo..IRQo, COUNTo   : status flags and fill level
module uart_rx_fifo_lvl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_W,
  parameter int FIFO_DEPTH = 16,
  parameter int LOG2_DEPTH = $clog2(FIFO_DEPTH),
  parameter int SHOW_AHEAD = 1,
  parameter int TOUT_CYC   = 1024
) (
  input  logic                  CLKip,
  input  logic                  RSTi,
  input  logic                  WEi,
  input  logic [DATA_WIDTH-1:0] WDi,
  input  logic                  WERRi,
  input  logic                  REi,
  output logic [DATA_WIDTH-1:0] RDo,
  output logic                  RERRo,
  output logic                  RVALIDo,
  input  logic                  FLUSHi,
  input  logic                  CLRi,
  input  logic [LOG2_DEPTH:0]   AFULL_THi,
  input  logic [LOG2_DEPTH:0]   AEMPTY_THi,
  output logic                  FULLo,
  output logic                  EMPTYo,
  output logic                  AFULLo,
  output logic                  AEMPTYo,
  output logic                  OVFo,
  output logic                  UDFo,
  output logic                  TOUTo,
  output logic                  IRQo,
  output logic [LOG2_DEPTH:0]   COUNTo
);

  localparam int       PW   = LOG2_DEPTH + 1;
  localparam rd_mode_e MODE = (SHOW_AHEAD != 0) ? RD_SHOW_AHEAD : RD_REGISTERED;

  logic [PW-1:0] wr_ptr, rd_ptr, count;
  logic          full, empty;
  logic          rd_acc, wr_acc, rd_rej, wr_rej;
  logic          ovf, udf, irq, tout;
  uart_entry_t   mem [FIFO_DEPTH];
  uart_entry_t   head, wr_entry;

  // Extra pointer bit distinguishes full from empty; wrap is plain modulo.
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == PW'(FIFO_DEPTH));
  assign empty = (count == '0);

  // Flush discards same-cycle requests outright: no accept, no error flag.
  // A full FIFO still takes a write when a read frees the slot this cycle.
  assign rd_acc = REi & ~empty & ~FLUSHi;
  assign wr_acc = WEi & (~full | rd_acc) & ~FLUSHi;
  assign rd_rej = REi & empty & ~FLUSHi;
  assign wr_rej = WEi & ~wr_acc & ~FLUSHi;

  always_ff @(posedge CLKip or negedge RSTi) begin
    if (!RSTi) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (FLUSHi) begin
      rd_ptr <= wr_ptr;
    end else begin
      wr_ptr <= wr_ptr + PW'(wr_acc);
      rd_ptr <= rd_ptr + PW'(rd_acc);
    end
  end

  // Storage is not reset; pointers alone define what is valid.
  assign wr_entry = '{err: WERRi, data: UART_DATA_W'(WDi)};

  always_ff @(posedge CLKip) begin
    if (wr_acc) mem[wr_ptr[LOG2_DEPTH-1:0]] <= wr_entry;
  end

  // Read of the old head happens before the same-edge write lands, so a
  // full-FIFO read+write to one slot returns the old entry.
  assign head = mem[rd_ptr[LOG2_DEPTH-1:0]];

  if (MODE == RD_SHOW_AHEAD) begin : g_show_ahead
    // Masked while empty so the port reads 0 out of reset, not stale memory.
    assign RDo     = empty ? '0 : DATA_WIDTH'(head.data);
    assign RERRo   = ~empty & head.err;
    assign RVALIDo = ~empty;
  end else begin : g_registered
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  rerr_q, rvld_q;

    always_ff @(posedge CLKip or negedge RSTi) begin
      if (!RSTi) begin
        rd_q   <= '0;
        rerr_q <= 1'b0;
        rvld_q <= 1'b0;
      end else begin
        rvld_q <= rd_acc;
        if (rd_acc) begin
          rd_q   <= DATA_WIDTH'(head.data);
          rerr_q <= head.err;
        end
      end
    end

    assign RDo     = rd_q;
    assign RERRo   = rerr_q;
    assign RVALIDo = rvld_q;
  end

  uart_fifo_tout #(.TOUT_CYC(TOUT_CYC)) u_tout (
    .CLKip (CLKip),
    .RSTi  (RSTi),
    .ACTi  (wr_acc | rd_acc),
    .EMPTYi(empty),
    .FLUSHi(FLUSHi),
    .TOUTo (tout)
  );

  // Sticky errors: clear wins over a same-cycle set.
  always_ff @(posedge CLKip or negedge RSTi) begin
    if (!RSTi) begin
      ovf <= 1'b0;
      udf <= 1'b0;
      irq <= 1'b0;
    end else begin
      ovf <= ~CLRi & (ovf | wr_rej);
      udf <= ~CLRi & (udf | rd_rej);
      irq <= AFULLo | tout | ovf | udf;
    end
  end

  assign COUNTo  = count;
  assign FULLo   = full;
  assign EMPTYo  = empty;
  assign AFULLo  = (count >= AFULL_THi);
  assign AEMPTYo = (count <= AEMPTY_THi);
  assign OVFo    = ovf;
  assign UDFo    = udf;
  assign TOUTo   = tout;
  assign IRQo    = irq;

endmodule

// File: tb/tb_uart_rx_fifo_lvl.sv
module tb_uart_rx_fifo_lvl;

  logic       clk, rst_n;
  logic       we, werr, re, flush, clr;
  logic [7:0] wd;
  logic [4:0] afth, aeth;

  logic [7:0] sa_rd, rg_rd;
  logic       sa_rerr, sa_rvalid, rg_rerr, rg_rvalid;
  logic       sa_full, sa_empty, sa_afull, sa_aempty, sa_ovf, sa_udf, sa_tout, sa_irq;
  logic       rg_full, rg_empty, rg_afull, rg_aempty, rg_ovf, rg_udf, rg_tout, rg_irq;
  logic [4:0] sa_cnt, rg_cnt;

  int checks = 0;
  int errors = 0;
  int lvl    = 0;
  logic [8:0] sa_q[$];
  logic [8:0] rg_q[$];
  logic [8:0] sa_exp, rg_exp;

  uart_rx_fifo_lvl #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .SHOW_AHEAD(1), .TOUT_CYC(8)) dut_sa (
    .CLKip(clk), .RSTi(rst_n), .WEi(we), .WDi(wd), .WERRi(werr), .REi(re),
    .RDo(sa_rd), .RERRo(sa_rerr), .RVALIDo(sa_rvalid), .FLUSHi(flush), .CLRi(clr),
    .AFULL_THi(afth), .AEMPTY_THi(aeth), .FULLo(sa_full), .EMPTYo(sa_empty),
    .AFULLo(sa_afull), .AEMPTYo(sa_aempty), .OVFo(sa_ovf), .UDFo(sa_udf),
    .TOUTo(sa_tout), .IRQo(sa_irq), .COUNTo(sa_cnt));

  uart_rx_fifo_lvl #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .SHOW_AHEAD(0), .TOUT_CYC(8)) dut_rg (
    .CLKip(clk), .RSTi(rst_n), .WEi(we), .WDi(wd), .WERRi(werr), .REi(re),
    .RDo(rg_rd), .RERRo(rg_rerr), .RVALIDo(rg_rvalid), .FLUSHi(flush), .CLRi(clr),
    .AFULL_THi(afth), .AEMPTY_THi(aeth), .FULLo(rg_full), .EMPTYo(rg_empty),
    .AFULLo(rg_afull), .AEMPTYo(rg_aempty), .OVFo(rg_ovf), .UDFo(rg_udf),
    .TOUTo(rg_tout), .IRQo(rg_irq), .COUNTo(rg_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one cycle of stimulus; expected read data is queued for the monitor.
  task automatic op(input bit w, input logic [7:0] d, input bit e, input bit r, input bit f);
    bit rok, wok;
    we = w; wd = d; werr = e; re = r; flush = f;
    if (f) begin
      sa_q.delete(); rg_q.delete(); lvl = 0;
    end else begin
      rok = r && (lvl > 0);
      wok = w && ((lvl < 16) || rok);
      if (wok) begin sa_q.push_back({e, d}); rg_q.push_back({e, d}); end
      lvl = lvl + int'(wok) - int'(rok);
    end
    cyc();
    we = 1'b0; re = 1'b0; flush = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  // Monitor: show-ahead data is checked on the cycle a read is accepted,
  // registered data on the cycle its RVALIDo is presented.
  always @(negedge clk) begin
    if (rst_n && re && !flush && sa_rvalid) begin
      if (sa_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sa_pop: read accepted with nothing expected, got %0h", {sa_rerr, sa_rd});
      end else begin
        sa_exp = sa_q.pop_front();
        chk("sa_rd", {23'd0, sa_rerr, sa_rd}, {23'd0, sa_exp});
      end
    end
    if (rst_n && rg_rvalid) begin
      if (rg_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rg_pop: RVALIDo with nothing expected, got %0h", {rg_rerr, rg_rd});
      end else begin
        rg_exp = rg_q.pop_front();
        chk("rg_rd", {23'd0, rg_rerr, rg_rd}, {23'd0, rg_exp});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 100000", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; we = 0; werr = 0; re = 0; flush = 0; clr = 0; wd = '0;
    afth = 5'd12; aeth = 5'd2;
    #1;
    chk("rst_cnt", sa_cnt, 0);      chk("rst_empty", sa_empty, 1);
    chk("rst_full", sa_full, 0);    chk("rst_irq", sa_irq, 0);
    chk("rst_rg_rvalid", rg_rvalid, 0); chk("rst_rg_rd", rg_rd, 0);
    chk("rst_sa_rvalid", sa_rvalid, 0);
    #12 rst_n = 1'b1;
    cyc();

    // Fill sweep 0..16 with thresholds, 17th write overflows.
    for (int i = 0; i <= 16; i++) begin
      chk("lvl_cnt", sa_cnt, i);
      chk("lvl_afull", sa_afull, (i >= 12));
      chk("lvl_aempty", sa_aempty, (i <= 2));
      chk("lvl_full", sa_full, (i == 16));
      chk("lvl_irq", sa_irq, (i >= 13));
      chk("lvl_rg_afull", rg_afull, (i >= 12));
      op(1, 8'(i), 0, 0, 0);
    end
    chk("ovf_cnt", sa_cnt, 16);  chk("ovf_full", sa_full, 1);
    chk("ovf_set", sa_ovf, 1);   chk("ovf_rg", rg_ovf, 1);
    pulse_clr();
    chk("ovf_clr", sa_ovf, 0);
    for (int i = 0; i < 16; i++) op(0, 0, 0, 1, 0);
    chk("drain_empty", sa_empty, 1);
    op(0, 0, 0, 1, 0);
    chk("udf_set", sa_udf, 1);   chk("udf_irq_lag", sa_irq, 0);
    pulse_clr();
    chk("udf_clr", sa_udf, 0);   chk("udf_irq", sa_irq, 1);
    cyc();
    chk("irq_fall", sa_irq, 0);

    // Full simultaneous read/write.
    for (int i = 0; i < 16; i++) op(1, 8'h20 + 8'(i), 0, 0, 0);
    chk("frw_full_pre", sa_full, 1);
    op(1, 8'hAA, 0, 1, 0);
    chk("frw_cnt", sa_cnt, 16);  chk("frw_ovf", sa_ovf, 0);
    for (int i = 0; i < 15; i++) op(0, 0, 0, 1, 0);
    chk("frw_last", sa_rd, 8'hAA);
    op(0, 0, 0, 1, 0);
    chk("frw_empty", sa_empty, 1);

    // Registered mode with error tag.
    op(1, 8'h55, 1, 0, 0);
    chk("sa_head", sa_rd, 8'h55);  chk("sa_head_err", sa_rerr, 1);
    chk("rg_novld", rg_rvalid, 0);
    op(0, 0, 0, 1, 0);
    chk("rg_data", rg_rd, 8'h55);  chk("rg_err", rg_rerr, 1);
    chk("rg_vld", rg_rvalid, 1);
    cyc();
    chk("rg_vld_fall", rg_rvalid, 0); chk("rg_hold", rg_rd, 8'h55);

    // Timeout.
    repeat (10) cyc();
    chk("tout_empty", sa_tout, 0);
    op(1, 8'h3C, 0, 0, 0);
    repeat (7) cyc();
    chk("tout_7", sa_tout, 0);
    cyc();
    chk("tout_8", sa_tout, 1);     chk("tout_rg", rg_tout, 1);
    cyc();
    chk("tout_irq", sa_irq, 1);
    op(0, 0, 0, 1, 0);
    chk("tout_clr", sa_tout, 0);
    repeat (10) cyc();
    chk("tout_empty2", sa_tout, 0);

    // Flush with same-cycle write and read.
    for (int i = 0; i < 5; i++) op(1, 8'h40 + 8'(i), 0, 0, 0);
    chk("fl_pre", sa_cnt, 5);
    op(1, 8'h77, 0, 1, 1);
    chk("fl_cnt", sa_cnt, 0);      chk("fl_empty", sa_empty, 1);
    chk("fl_ovf", sa_ovf, 0);      chk("fl_udf", sa_udf, 0);
    chk("fl_rg_hold", rg_rd, 8'h3C); chk("fl_rg_vld", rg_rvalid, 0);
    op(1, 8'h5A, 0, 0, 0);
    chk("fl_after", sa_cnt, 1);
    op(0, 0, 0, 1, 0);

    // Reset mid-burst.
    op(0, 0, 0, 1, 0);
    cyc();
    chk("pre_rst_udf", sa_udf, 1);
    op(1, 8'h61, 0, 0, 0); op(1, 8'h62, 0, 0, 0); op(1, 8'h63, 0, 0, 0);
    we = 1'b1; wd = 8'h64;
    #3 rst_n = 1'b0;
    #1;
    chk("mr_cnt", sa_cnt, 0);      chk("mr_empty", sa_empty, 1);
    chk("mr_udf", sa_udf, 0);      chk("mr_ovf", sa_ovf, 0);
    chk("mr_tout", sa_tout, 0);    chk("mr_irq", sa_irq, 0);
    chk("mr_sa_rd", sa_rd, 0);     chk("mr_sa_vld", sa_rvalid, 0);
    chk("mr_rg_rd", rg_rd, 0);     chk("mr_rg_err", rg_rerr, 0);
    chk("mr_rg_cnt", rg_cnt, 0);
    we = 1'b0;
    sa_q.delete(); rg_q.delete(); lvl = 0;
    #2 rst_n = 1'b1;
    op(1, 8'h99, 0, 0, 0);
    chk("post_rst_cnt", sa_cnt, 1);
    op(0, 0, 0, 1, 0);
    repeat (3) cyc();
    chk("sa_q_left", sa_q.size(), 0);
    chk("rg_q_left", rg_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
